// File: rtl/io_uart_pkg.sv
`default_nettype none
// ============================================================================
// io_uart_pkg : shared types, constants and round-robin helper for UART TX
// Revision    : 1.0
// ============================================================================
package io_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int MAX_REQ   = 32;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_pick_t;

  // First asserted bit of valid[n-1:0], searching upward from ptr and wrapping.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input int unsigned        ptr,
                                       input int unsigned        n);
    rr_pick_t          res;
    logic [MAX_REQ-1:0] rot;
    int unsigned        j;
    res.found = 1'b0;
    res.idx   = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      j = ptr + i;
      if (j >= n) j = j - n;
      rot = valid >> j;
      if (i < n && !res.found && rot[0]) begin
        res.found = 1'b1;
        res.idx   = j;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_uart_baud_counter.sv
`default_nettype none
// ============================================================================
// io_uart_baud_counter : restartable bit-period tick generator
// Revision             : 1.0
// ============================================================================
module io_uart_baud_counter #(
  parameter int BIT_PERIOD = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    tick    = (count_q == CNT_W'(BIT_PERIOD - 1));
    count_d = count_q + CNT_W'(1);
    // Clear on accept has priority so bit edges align to the frame start.
    if (clear || tick) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule
`default_nettype wire

// File: rtl/io_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// io_uart_tx_arbiter : round-robin shared UART transmitter, 8N1 framing
// Revision           : 1.0
// ============================================================================
module io_uart_tx_arbiter
  import io_uart_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int CLOCK_FREQ = 100000000,
  parameter  int BAUD_RATE  = 115200,
  parameter  int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE,
  localparam int GRANT_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [GRANT_W-1:0]   grant_id
);

  if (BIT_PERIOD < 2 || NUM_REQ < 1 || NUM_REQ > MAX_REQ) begin : g_param_check
    $error("io_uart_tx_arbiter: BIT_PERIOD must be >= 2 and NUM_REQ in 1..MAX_REQ");
  end

  tx_state_t          state_q, state_d;
  logic               tx_q, tx_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [GRANT_W-1:0] rr_q, rr_d;
  logic [GRANT_W-1:0] grant_q, grant_d;

  rr_pick_t           pick;
  logic [GRANT_W-1:0] winner;
  logic [7:0]         win_byte;
  logic               accept;
  logic               tick;

  io_uart_baud_counter #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .tick  (tick)
  );

  always_comb begin
    pick   = rr_pick(MAX_REQ'(req_valid), 32'(rr_q), NUM_REQ);
    winner = GRANT_W'(pick.idx);

    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == GRANT_W'(i)) win_byte = req_data[i*8 +: 8];
    end

    req_ready = '0;
    if (state_q == IDLE && !reset && pick.found) req_ready = NUM_REQ'(1) << winner;
    accept = |(req_valid & req_ready);

    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    rr_d      = rr_q;
    grant_d   = grant_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          tx_d    = 1'b0;
          shift_d = win_byte;
          grant_d = winner;
          rr_d    = (winner == GRANT_W'(NUM_REQ - 1)) ? '0 : winner + GRANT_W'(1);
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = '0;
        end
      end
      DATA: begin
        // bit_idx names the data bit currently on the line.
        if (tick) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d   = STOP;
            tx_d      = 1'b1;
            bit_idx_d = '0;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) state_d = IDLE;
          else                                bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_idx_q <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule
`default_nettype wire
